mem_responder: RTL and testbench

- Memory-side endpoint of the L2 memory request/response protocol: accepts read/write requests from a cache master and returns read data tagged with the request tag.
- Backed by an internal word-addressed RAM, with a fixed read latency and a bounded response queue honouring response backpressure.
- Serves as the standalone memory model for a compute unit's L2 instruction and data ports in block/subsystem benches, and as the on-chip scratch memory in small configurations.

---
 rtl/mem_responder.sv | 185 ++++++++++++++++++
 tb/tb_mem_responder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-side L2 endpoint: word-addressed RAM, fixed-latency tagged reads, credit-gated in-order response FIFO.
// Define MEM_RESPONDER_PERF_EN to build the read/write/stall performance counters.
module mem_responder #(
    parameter int unsigned DATA_WIDTH     = 512,
    parameter int unsigned ADDR_WIDTH     = 26,
    parameter int unsigned TAG_WIDTH      = 8,
    parameter int unsigned DEPTH_LOG2     = 10,
    parameter int unsigned LATENCY        = 4,
    parameter int unsigned RSP_FIFO_DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    input  logic                    req_rw_i,
    input  logic [DATA_WIDTH/8-1:0] req_byteen_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [DATA_WIDTH-1:0]   req_data_i,
    input  logic [TAG_WIDTH-1:0]    req_tag_i,
    output logic                    req_ready_o,
    output logic                    rsp_valid_o,
    output logic [DATA_WIDTH-1:0]   rsp_data_o,
    output logic [TAG_WIDTH-1:0]    rsp_tag_o,
    input  logic                    rsp_ready_i,
    output logic [31:0]             perf_reads_o,
    output logic [31:0]             perf_writes_o,
    output logic [31:0]             perf_stalls_o
);
    localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
    localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
    localparam int unsigned PTR_WIDTH = $clog2(RSP_FIFO_DEPTH);
    localparam int unsigned CNT_WIDTH = $clog2(RSP_FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] idx;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  unused_addr;

    logic                  arr_valid;
    logic [DATA_WIDTH-1:0] arr_data;
    logic [TAG_WIDTH-1:0]  arr_tag;

    logic [DATA_WIDTH-1:0] fifo_data [RSP_FIFO_DEPTH];
    logic [TAG_WIDTH-1:0]  fifo_tag  [RSP_FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [CNT_WIDTH-1:0]  fifo_cnt;
    logic [CNT_WIDTH-1:0]  outstanding;
    logic [CNT_WIDTH-1:0]  outstanding_nxt;
    logic                  rsp_hs;
    logic                  out_free;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;

    // Upper address bits alias onto the RAM index by design.
    assign idx         = req_addr_i[DEPTH_LOG2-1:0];
    assign unused_addr = ^req_addr_i[ADDR_WIDTH-1:DEPTH_LOG2];

    assign wr_acc = req_valid_i & req_ready_o & req_rw_i & ~rst_i;
    assign rd_acc = req_valid_i & req_ready_o & ~req_rw_i;

    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            for (int unsigned i = 0; i < BE_WIDTH; i++) begin
                if (req_byteen_i[i]) begin
                    mem[idx][i*8 +: 8] <= req_data_i[i*8 +: 8];
                end
            end
        end
    end

    // RAM is sampled at the accept edge; the last stage feeds the response queue.
    if (LATENCY == 1) begin : g_direct
        assign arr_valid = rd_acc;
        assign arr_data  = mem[idx];
        assign arr_tag   = req_tag_i;
    end else begin : g_pipe
        localparam int unsigned STAGES = LATENCY - 1;
        logic [STAGES-1:0]     stage_valid;
        logic [DATA_WIDTH-1:0] stage_data [STAGES];
        logic [TAG_WIDTH-1:0]  stage_tag  [STAGES];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                stage_valid <= '0;
            end else begin
                stage_valid[0] <= rd_acc;
                for (int unsigned i = 1; i < STAGES; i++) begin
                    stage_valid[i] <= stage_valid[i-1];
                end
            end
        end

        always_ff @(posedge clk_i) begin
            stage_data[0] <= mem[idx];
            stage_tag[0]  <= req_tag_i;
            for (int unsigned i = 1; i < STAGES; i++) begin
                stage_data[i] <= stage_data[i-1];
                stage_tag[i]  <= stage_tag[i-1];
            end
        end

        assign arr_valid = stage_valid[STAGES-1];
        assign arr_data  = stage_data[STAGES-1];
        assign arr_tag   = stage_tag[STAGES-1];
    end

    // Arrivals bypass the FIFO when it is empty and the output register can take them.
    assign rsp_hs     = rsp_valid_o & rsp_ready_i;
    assign out_free   = ~rsp_valid_o | rsp_ready_i;
    assign fifo_empty = (fifo_cnt == '0);
    assign pop        = out_free & ~fifo_empty;
    assign push       = arr_valid & ~(out_free & fifo_empty);

    assign outstanding_nxt = outstanding + CNT_WIDTH'(rd_acc) - CNT_WIDTH'(rsp_hs);

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_data[wr_ptr] <= arr_data;
            fifo_tag[wr_ptr]  <= arr_tag;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            outstanding <= '0;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_tag_o   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            fifo_cnt    <= fifo_cnt + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
            outstanding <= outstanding_nxt;
            req_ready_o <= (outstanding_nxt < CNT_WIDTH'(RSP_FIFO_DEPTH));
            if (out_free) begin
                if (!fifo_empty) begin
                    rsp_valid_o <= 1'b1;
                    rsp_data_o  <= fifo_data[rd_ptr];
                    rsp_tag_o   <= fifo_tag[rd_ptr];
                end else if (arr_valid) begin
                    rsp_valid_o <= 1'b1;
                    rsp_data_o  <= arr_data;
                    rsp_tag_o   <= arr_tag;
                end else begin
                    rsp_valid_o <= 1'b0;
                end
            end
        end
    end

`ifdef MEM_RESPONDER_PERF_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_reads_o  <= '0;
            perf_writes_o <= '0;
            perf_stalls_o <= '0;
        end else begin
            if (rd_acc) begin
                perf_reads_o <= perf_reads_o + 32'd1;
            end
            if (wr_acc) begin
                perf_writes_o <= perf_writes_o + 32'd1;
            end
            if (req_valid_i && !req_ready_o) begin
                perf_stalls_o <= perf_stalls_o + 32'd1;
            end
        end
    end
`else
    assign perf_reads_o  = '0;
    assign perf_writes_o = '0;
    assign perf_stalls_o = '0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a queue-based reference model of the request/response protocol.
// Honours MEM_RESPONDER_PERF_EN when deciding the expected performance counter values.
module tb_mem_responder;
    localparam int unsigned DW  = 512;
    localparam int unsigned AW  = 26;
    localparam int unsigned TW  = 8;
    localparam int unsigned DL  = 10;
    localparam int unsigned LAT = 4;
    localparam int unsigned FD  = 4;
    localparam int unsigned BW  = DW / 8;
`ifdef MEM_RESPONDER_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          req_valid_i = 1'b0;
    logic          req_rw_i = 1'b0;
    logic [BW-1:0] req_byteen_i = '0;
    logic [AW-1:0] req_addr_i = '0;
    logic [DW-1:0] req_data_i = '0;
    logic [TW-1:0] req_tag_i = '0;
    logic          req_ready_o;
    logic          rsp_valid_o;
    logic [DW-1:0] rsp_data_o;
    logic [TW-1:0] rsp_tag_o;
    logic          rsp_ready_i = 1'b0;
    logic [31:0]   perf_reads_o;
    logic [31:0]   perf_writes_o;
    logic [31:0]   perf_stalls_o;

    always #5 clk = ~clk;

    mem_responder #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
        .DEPTH_LOG2(DL), .LATENCY(LAT), .RSP_FIFO_DEPTH(FD)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_rw_i(req_rw_i), .req_byteen_i(req_byteen_i),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_tag_i(req_tag_i),
        .req_ready_o(req_ready_o),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_tag_o(rsp_tag_o),
        .rsp_ready_i(rsp_ready_i),
        .perf_reads_o(perf_reads_o), .perf_writes_o(perf_writes_o), .perf_stalls_o(perf_stalls_o)
    );

    // Reference model: pending reads in accept order, each with its earliest visible cycle.
    typedef struct {
        logic [DW-1:0] d;
        logic [TW-1:0] t;
        int            vis;
    } rsp_t;

    rsp_t          exp_q[$];
    logic [DW-1:0] ref_mem [1 << DL];
    logic [DW-1:0] last_d = '0;
    logic [TW-1:0] last_t = '0;
    int            outst = 0;
    int            cyc = 0;
    int            n_rd = 0;
    int            n_wr = 0;
    int            n_st = 0;
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] perf_exp(input int n);
        return PERF ? DW'(32'(n)) : '0;
    endfunction

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] r;
        for (int i = 0; i < int'(DW / 32); i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // One cycle: check outputs against the model, drive inputs, advance the model, move to next negedge.
    task automatic step(input logic v, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [BW-1:0] be, input logic [TW-1:0] tg, input logic rr);
        logic          er;
        logic          ev;
        logic [DW-1:0] hd;
        logic [TW-1:0] ht;
        int            ix;
        er = (outst < int'(FD));
        ev = 1'b0;
        hd = last_d;
        ht = last_t;
        if (exp_q.size() > 0) begin
            if (exp_q[0].vis <= cyc) begin
                ev = 1'b1;
                hd = exp_q[0].d;
                ht = exp_q[0].t;
            end
        end
        check("req_ready", DW'(req_ready_o), DW'(er));
        check("rsp_valid", DW'(rsp_valid_o), DW'(ev));
        check("rsp_data", rsp_data_o, hd);
        check("rsp_tag", DW'(rsp_tag_o), DW'(ht));
        check("perf_reads", DW'(perf_reads_o), perf_exp(n_rd));
        check("perf_writes", DW'(perf_writes_o), perf_exp(n_wr));
        check("perf_stalls", DW'(perf_stalls_o), perf_exp(n_st));

        req_valid_i  = v;
        req_rw_i     = rw;
        req_addr_i   = a;
        req_data_i   = d;
        req_byteen_i = be;
        req_tag_i    = tg;
        rsp_ready_i  = rr;

        if (rr && ev) begin
            last_d = hd;
            last_t = ht;
            void'(exp_q.pop_front());
            outst--;
        end
        if (v && !er) n_st++;
        if (v && er) begin
            ix = int'(a[DL-1:0]);
            if (rw) begin
                n_wr++;
                for (int i = 0; i < int'(BW); i++)
                    if (be[i]) ref_mem[ix][i*8 +: 8] = d[i*8 +: 8];
            end else begin
                n_rd++;
                exp_q.push_back('{ref_mem[ix], tg, cyc + int'(LAT)});
                outst++;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n, input logic rr);
        repeat (n) step(1'b0, 1'b0, '0, '0, '0, '0, rr);
    endtask

    task automatic do_reset();
        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b0;
        @(negedge clk);
        cyc++;
        rst_i = 1'b0;
        exp_q.delete();
        outst  = 0;
        last_d = '0;
        last_t = '0;
        n_rd   = 0;
        n_wr   = 0;
        n_st   = 0;
    endtask

    // Read from an idle responder and check the response at exactly LAT cycles with constant expectations.
    task automatic read_expect(input logic [AW-1:0] a, input logic [TW-1:0] tg, input logic [DW-1:0] exp_d);
        step(1'b1, 1'b0, a, '0, '0, tg, 1'b0);
        idle(int'(LAT) - 1, 1'b0);
        check("lat_valid", DW'(rsp_valid_o), DW'(1'b1));
        check("lat_data", rsp_data_o, exp_d);
        check("lat_tag", DW'(rsp_tag_o), DW'(tg));
        idle(1, 1'b1);
    endtask

    logic [DW-1:0] a5;
    logic [DW-1:0] pat;
    logic [DW-1:0] wd;
    logic [AW-1:0] ra;

    initial begin
        do_reset();
        check("rst_ready", DW'(req_ready_o), DW'(1'b1));
        check("rst_valid", DW'(rsp_valid_o), '0);
        check("rst_data", rsp_data_o, '0);
        check("rst_tag", DW'(rsp_tag_o), '0);
        idle(2, 1'b1);

        // Full write then read; partial write; aliased read.
        a5 = {BW{8'hA5}};
        step(1'b1, 1'b1, AW'('h5), a5, '1, '0, 1'b1);
        read_expect(AW'('h5), 8'h03, a5);
        wd = rand_line();
        wd[7:0] = 8'h11;
        pat = a5;
        pat[7:0] = 8'h11;
        step(1'b1, 1'b1, AW'('h5), wd, BW'(1), '0, 1'b1);
        read_expect(AW'('h5), 8'h07, pat);
        read_expect(AW'('h405), 8'h09, pat);

        // Backpressure: four reads fill the credits, the fifth waits for the first drain.
        for (int t = 1; t <= 5; t++) step(1'b1, 1'b0, AW'('h5), '0, '0, TW'(t), 1'b0);
        check("bp_ready", DW'(req_ready_o), '0);
        step(1'b1, 1'b0, AW'('h5), '0, '0, TW'(5), 1'b1);
        step(1'b1, 1'b0, AW'('h5), '0, '0, TW'(5), 1'b1);
        idle(12, 1'b1);

        // Reset with reads in flight: nothing emerges, RAM persists.
        step(1'b1, 1'b0, AW'('h5), '0, '0, 8'h31, 1'b0);
        step(1'b1, 1'b0, AW'('h5), '0, '0, 8'h32, 1'b0);
        do_reset();
        check("rst2_ready", DW'(req_ready_o), DW'(1'b1));
        idle(10, 1'b1);
        read_expect(AW'('h5), 8'h21, pat);

        // Random traffic over eight aliased indices.
        for (int i = 0; i < 8; i++) begin
            ra = AW'($urandom);
            ra[DL-1:0] = DL'(i);
            step(1'b1, 1'b1, ra, rand_line(), '1, '0, 1'b1);
        end
        for (int i = 0; i < 1500; i++) begin
            ra = AW'($urandom);
            ra[DL-1:0] = DL'($urandom_range(0, 7));
            step(($urandom % 4) != 0, $urandom_range(0, 1) == 1, ra, rand_line(),
                 {$urandom, $urandom}, TW'($urandom), ($urandom % 4) != 0);
        end
        idle(20, 1'b1);

        // Performance counters: 3 writes, 6 reads, 2 stalled cycles.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, AW'(i), rand_line(), '1, '0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, AW'(i % 3), '0, '0, TW'(i), 1'b0);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, AW'(1), '0, '0, 8'hEE, 1'b0);
        idle(12, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, AW'(2), '0, '0, TW'(8 + i), 1'b1);
        idle(8, 1'b1);
        check("perf_writes_end", DW'(perf_writes_o), PERF ? DW'(3) : '0);
        check("perf_reads_end", DW'(perf_reads_o), PERF ? DW'(6) : '0);
        check("perf_stalls_end", DW'(perf_stalls_o), PERF ? DW'(2) : '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
